bus_interconnect: RTL
=====================

# bus_interconnect

Registered, parametrised single-master to N-slave memory-mapped interconnect; successor to the four-way combinational address-split bus. Sits between the core's data-memory port and the peripheral slaves (memory, GPIO, UART, timers), and adds what the combinational split lacks: latched transactions, configurable slave count, and an error response for unmapped addresses, conflicting strobes and slaves that never respond.

## Interface
- NUM_SLAVES, 4, number of slave ports (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- SEL_BITS, 2, top address bits used as slave index; requires 2^SEL_BITS >= NUM_SLAVES
- TIMEOUT_CYCLES, 255, cycles to wait for a slave response before reporting an error (>=1)
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- read  in  1  master read request
- write  in  1  master write request
- address  in  ADDR_WIDTH  master address
- write_data  in  DATA_WIDTH  master write data
- read_data  out  DATA_WIDTH  completed read data; holds until the next completion
- response  out  1  one-cycle completion pulse
- error  out  1  qualifies response: 1 = failed transaction
- slave_read  out  NUM_SLAVES  per-slave read strobe, one-hot or zero
- slave_write  out  NUM_SLAVES  per-slave write strobe, one-hot or zero
- slave_address  out  ADDR_WIDTH  latched address, shared by all slaves
- slave_write_data  out  DATA_WIDTH  latched write data, shared by all slaves
- slave_read_data  in  NUM_SLAVES*DATA_WIDTH  slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- slave_response  in  NUM_SLAVES  per-slave completion

## Operation
- Slave index = address[ADDR_WIDTH-1 -: SEL_BITS]. An index >= NUM_SLAVES is unmapped.
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - On read|write: latch address, write_data, operation and index.
  - Valid request to a mapped slave -> ACCESS.
  - Unmapped index, or read and write both high -> RESP with error=1. No slave strobe is asserted.
- ACCESS
  - The selected slave's read or write strobe is held high every cycle until the transaction ends.
  - The timeout counter increments each cycle.
  - Selected slave_response = 1 -> RESP. On the same edge: clear strobes; capture the slave's read data if the operation is a read (read_data is not changed by writes); error=0.
  - Counter reaches TIMEOUT_CYCLES with no response -> RESP. On the same edge: clear strobes; read_data=0; error=1.
- RESP: response=1 for exactly one cycle, then IDLE.
- Master inputs are ignored outside IDLE. A request still held high in IDLE starts a new transaction; masters must drop strobes on the response cycle.
- slave_response from non-selected slaves, and any slave_response outside ACCESS, is ignored. A late response after a timeout is also ignored.
- Reset values: state=IDLE; every output 0, including read_data, error, slave strobes, slave_address and slave_write_data; counter 0.
- Reset asserted mid-transaction aborts it on that edge: strobes drop, no response is issued.

## Timing
- Request sampled at edge 0 -> slave strobe visible in cycle 1.
- Slave response sampled at edge k -> master response high during cycle k+1. Minimum request-to-response is 2 cycles (slave responding combinationally in cycle 1).
- Unmapped or conflicting request at edge 0 -> response+error in cycle 1.
- Timeout: strobe held for TIMEOUT_CYCLES cycles, then response+error in the next cycle.
- Back-to-back: the earliest next acceptance is the cycle after the response pulse (the one-cycle IDLE gap).
- Counter width clog2(TIMEOUT_CYCLES+1); it clears on every entry to ACCESS and never wraps.

## Structure
- Shared package bus_pkg holds:
  - the state encoding (IDLE/ACCESS/RESP);
  - the BUS_ERROR_DATA constant (0);
  - the slave-index helper function (address -> index, mapped flag).
- Sub-module bus_timeout_counter: clear and enable inputs, an expired output, parameter TIMEOUT_CYCLES.
- Read-data mux and strobe decode stay inline.

## Test plan
- Read slave 2 at 0x8000_0010 (NUM_SLAVES=4); slave 2 responds in cycle 3 with 0x1234_5678 -> slave_read=4'b0100 cycles 1-3, response cycle 4, read_data=0x1234_5678, error=0.
- Write 0xCAFE_F00D to 0x4000_0004 -> slave_write=4'b0010, slave_write_data=0xCAFE_F00D, one response, read_data unchanged.
- NUM_SLAVES=3, read 0xC000_0000 -> no strobe, response+error in cycle 1, read_data=0.
- Slave 0 silent, TIMEOUT_CYCLES=8 -> strobe high 8 cycles, then response+error and read_data=0. A slave_response two cycles later is ignored.
- read and write both high -> error response, no strobe. Reset pulled low during ACCESS -> strobes 0 next cycle, no response.
- Two back-to-back reads to slaves 0 then 3 -> each gets exactly one response with the correct data; no strobe overlap between the two.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the registered single-master interconnect:
// FSM encoding, the error read-data value and the address-to-slave decode.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_t;

    localparam int unsigned BUS_ERROR_DATA = 0;
    localparam int unsigned SLAVE_IDX_W    = 4;

    typedef struct packed {
        logic                   mapped;
        logic [SLAVE_IDX_W-1:0] idx;
    } slave_sel_t;

    // Index taken from the top sel_bits of the address; anything at or above
    // num_slaves (including selectors wider than the index field) is unmapped.
    function automatic slave_sel_t slave_decode(input logic [63:0] addr,
                                                input int          addr_width,
                                                input int          sel_bits,
                                                input int          num_slaves);
        slave_sel_t  sel;
        logic [63:0] full_idx;
        full_idx   = (addr >> (addr_width - sel_bits)) & ((64'd1 << sel_bits) - 64'd1);
        sel.mapped = full_idx < 64'(num_slaves);
        sel.idx    = full_idx[SLAVE_IDX_W-1:0];
        return sel;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Slave-response watchdog: counts enabled cycles, expired is high combinationally
// in the TIMEOUT_CYCLES-th enabled cycle; saturates, never wraps.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The increment on this edge would reach the limit.
    assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_interconnect.sv
// Registered single-master to N-slave bus: request latched in IDLE, strobe held in ACCESS,
// one-cycle response pulse; minimum 2-cycle latency, error on unmapped/conflict/timeout.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_BITS       = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             read,
    input  logic                             write,
    input  logic [ADDR_WIDTH-1:0]            address,
    input  logic [DATA_WIDTH-1:0]            write_data,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic                             response,
    output logic                             error,
    output logic [NUM_SLAVES-1:0]            slave_read,
    output logic [NUM_SLAVES-1:0]            slave_write,
    output logic [ADDR_WIDTH-1:0]            slave_address,
    output logic [DATA_WIDTH-1:0]            slave_write_data,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_read_data,
    input  logic [NUM_SLAVES-1:0]            slave_response
);
    bus_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   op_read_q, op_read_d;
    logic                   err_q, err_d;
    logic [SLAVE_IDX_W-1:0] idx_q, idx_d;

    slave_sel_t             req_sel;
    logic                   sel_resp;
    logic [DATA_WIDTH-1:0]  sel_rdata;
    logic                   tmo_expired;
    logic                   in_access;

    assign req_sel   = slave_decode(64'(address), ADDR_WIDTH, SEL_BITS, NUM_SLAVES);
    assign in_access = (state_q == ST_ACCESS);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == ST_IDLE),
        .enable  (in_access),
        .expired (tmo_expired)
    );

    // Only the latched slave's response and data are observed.
    always_comb begin
        sel_resp  = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SLAVE_IDX_W'(i)) begin
                sel_resp  = slave_response[i];
                sel_rdata = slave_read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        slave_read  = '0;
        slave_write = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (in_access && (idx_q == SLAVE_IDX_W'(i))) begin
                slave_read[i]  = op_read_q;
                slave_write[i] = !op_read_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        op_read_d = op_read_q;
        err_d     = err_q;
        idx_d     = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (read || write) begin
                    addr_d    = address;
                    wdata_d   = write_data;
                    op_read_d = read;
                    idx_d     = req_sel.idx;
                    if ((read && write) || !req_sel.mapped) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = DATA_WIDTH'(BUS_ERROR_DATA);
                    end else begin
                        state_d = ST_ACCESS;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                // A response arriving on the expiry cycle still wins.
                if (sel_resp) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    if (op_read_q) begin
                        rdata_d = sel_rdata;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = DATA_WIDTH'(BUS_ERROR_DATA);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            op_read_q <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            op_read_q <= op_read_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
        end
    end

    assign read_data        = rdata_q;
    assign response         = (state_q == ST_RESP);
    assign error            = err_q;
    assign slave_address    = addr_q;
    assign slave_write_data = wdata_q;

endmodule
